// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank arbiter: FSM states, bank owner
// encoding and the default bank geometry.
package reg_bank_pkg;

    localparam int RB_N_REGS = 8;
    localparam int RB_ADDR_W = 3;
    localparam int RB_DATA_W = 32;
    localparam int RB_LEN_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_XFER    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/reg_read_mux.sv
// N_REGS:1 read-data selector. Picks the slice of the concatenated register
// outputs addressed by the arbiter's registered transfer address.
module reg_read_mux
    import reg_bank_pkg::*;
#(
    parameter int N_REGS = RB_N_REGS,
    parameter int ADDR_W = RB_ADDR_W,
    parameter int DATA_W = RB_DATA_W
) (
    input  logic [N_REGS*DATA_W-1:0] rdata_bus,
    input  logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        rdata
);

    assign rdata = rdata_bus[int'(addr)*DATA_W +: DATA_W];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Arbitrates a register bank between single-beat CPU accesses and
// incrementing DMA bursts, generating one-hot selects and read/write strobes.
// All control outputs are registered from the next-state values so they line
// up with the state they belong to; only reg_wdata passes DMA data straight
// through because DMA write beats are not latched by the requester.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int N_REGS = RB_N_REGS,
    parameter int ADDR_W = RB_ADDR_W,
    parameter int DATA_W = RB_DATA_W,
    parameter int LEN_W  = RB_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_done,
    output logic [DATA_W-1:0]        cpu_rdata,
    input  logic                     dma_req,
    input  logic                     dma_we,
    input  logic [ADDR_W-1:0]        dma_addr,
    input  logic [LEN_W-1:0]         dma_len,
    input  logic [DATA_W-1:0]        dma_wdata,
    output logic                     dma_gnt,
    output logic                     dma_done,
    output logic                     dma_beat,
    output logic [DATA_W-1:0]        dma_rdata,
    output logic [N_REGS-1:0]        reg_sel,
    output logic                     reg_wr,
    output logic                     reg_rd,
    output logic [DATA_W-1:0]        reg_wdata,
    input  logic [N_REGS*DATA_W-1:0] reg_rdata_bus
);

    state_t              state_r,      state_nxt_s;
    owner_t              owner_r,      owner_nxt_s;
    owner_t              last_owner_r, last_owner_nxt_s;
    logic                we_r,         we_nxt_s;
    logic [ADDR_W-1:0]   addr_r,       addr_nxt_s;
    logic [LEN_W-1:0]    cnt_r,        cnt_nxt_s;
    logic [DATA_W-1:0]   wdata_r,      wdata_nxt_s;

    logic                cpu_gnt_r,  cpu_done_r;
    logic                dma_gnt_r,  dma_done_r, dma_beat_r;
    logic                reg_wr_r,   reg_rd_r;
    logic [N_REGS-1:0]   reg_sel_r;
    logic [DATA_W-1:0]   cpu_rdata_r, dma_rdata_r;
    logic [DATA_W-1:0]   mux_rdata_s;

    reg_read_mux #(
        .N_REGS (N_REGS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_read_mux (
        .rdata_bus (reg_rdata_bus),
        .addr      (addr_r),
        .rdata     (mux_rdata_s)
    );

    // Next-state logic: arbitration, request latching and burst sequencing.
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_owner_nxt_s = last_owner_r;
        we_nxt_s         = we_r;
        addr_nxt_s       = addr_r;
        cnt_nxt_s        = cnt_r;
        wdata_nxt_s      = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req && dma_req) begin
                    // Tie: the side that did not own the bank last time wins.
                    owner_nxt_s = (last_owner_r == OWN_DMA) ? OWN_CPU : OWN_DMA;
                    state_nxt_s = ST_GRANT;
                end else if (cpu_req) begin
                    owner_nxt_s = OWN_CPU;
                    state_nxt_s = ST_GRANT;
                end else if (dma_req) begin
                    owner_nxt_s = OWN_DMA;
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_nxt_s = ST_XFER;
                if (owner_r == OWN_DMA) begin
                    we_nxt_s   = dma_we;
                    addr_nxt_s = dma_addr;
                    cnt_nxt_s  = dma_len;
                end else begin
                    we_nxt_s    = cpu_we;
                    addr_nxt_s  = cpu_addr;
                    cnt_nxt_s   = {LEN_W{1'b0}};
                    wdata_nxt_s = cpu_wdata;
                end
            end
            ST_XFER: begin
                if (!we_r) begin
                    state_nxt_s = ST_CAPTURE;
                end else if (cnt_r != {LEN_W{1'b0}}) begin
                    state_nxt_s = ST_XFER;
                    addr_nxt_s  = addr_r + ADDR_W'(1);
                    cnt_nxt_s   = cnt_r - LEN_W'(1);
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                if (cnt_r != {LEN_W{1'b0}}) begin
                    state_nxt_s = ST_XFER;
                    addr_nxt_s  = addr_r + ADDR_W'(1);
                    cnt_nxt_s   = cnt_r - LEN_W'(1);
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                last_owner_nxt_s = owner_r;
                state_nxt_s      = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, transfer context and registered outputs derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_DMA;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            cnt_r        <= {LEN_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            cpu_gnt_r    <= 1'b0;
            cpu_done_r   <= 1'b0;
            dma_gnt_r    <= 1'b0;
            dma_done_r   <= 1'b0;
            dma_beat_r   <= 1'b0;
            reg_wr_r     <= 1'b0;
            reg_rd_r     <= 1'b0;
            reg_sel_r    <= {N_REGS{1'b0}};
            cpu_rdata_r  <= {DATA_W{1'b0}};
            dma_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            we_r         <= we_nxt_s;
            addr_r       <= addr_nxt_s;
            cnt_r        <= cnt_nxt_s;
            wdata_r      <= wdata_nxt_s;
            cpu_gnt_r    <= (state_nxt_s == ST_GRANT) && (owner_nxt_s == OWN_CPU);
            dma_gnt_r    <= (state_nxt_s == ST_GRANT) && (owner_nxt_s == OWN_DMA);
            cpu_done_r   <= (state_nxt_s == ST_DONE)  && (owner_nxt_s == OWN_CPU);
            dma_done_r   <= (state_nxt_s == ST_DONE)  && (owner_nxt_s == OWN_DMA);
            reg_wr_r     <= (state_nxt_s == ST_XFER)  && we_nxt_s;
            reg_rd_r     <= (state_nxt_s == ST_XFER)  && !we_nxt_s;
            reg_sel_r    <= (state_nxt_s == ST_XFER) ? (N_REGS'(1) << addr_nxt_s)
                                                     : {N_REGS{1'b0}};
            // Write beats are consumed during XFER; read beats are presented
            // the cycle after their CAPTURE.
            dma_beat_r   <= (owner_nxt_s == OWN_DMA) &&
                            (((state_nxt_s == ST_XFER) && we_nxt_s) || (state_r == ST_CAPTURE));
            if (state_r == ST_CAPTURE && owner_r == OWN_CPU) begin
                cpu_rdata_r <= mux_rdata_s;
            end
            if (state_r == ST_CAPTURE && owner_r == OWN_DMA) begin
                dma_rdata_r <= mux_rdata_s;
            end
        end
    end

    assign cpu_gnt   = cpu_gnt_r;
    assign cpu_done  = cpu_done_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dma_gnt   = dma_gnt_r;
    assign dma_done  = dma_done_r;
    assign dma_beat  = dma_beat_r;
    assign dma_rdata = dma_rdata_r;
    assign reg_sel   = reg_sel_r;
    assign reg_wr    = reg_wr_r;
    assign reg_rd    = reg_rd_r;
    assign reg_wdata = reg_wr_r ? ((owner_r == OWN_DMA) ? dma_wdata : wdata_r)
                                : {DATA_W{1'b0}};

endmodule
